// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester single-port RAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } arb_state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_LD  = 1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational winner select between CPU (0) and loader (1).
// MEM_ARB_ROUND_ROBIN_EN: defined -> alternate on conflict using the
// last-served pointer; undefined -> CPU always wins conflicts.
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       win
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Loader wins when it is the only requester, or on conflict when the
    // CPU was served last.
    always_comb begin
        win = req[REQ_LD] & ~(req[REQ_CPU] & last);
    end
`else
    logic unused_last;
    assign unused_last = last;

    // Loader wins only when the CPU is not requesting.
    always_comb begin
        win = req[REQ_LD] & ~req[REQ_CPU];
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter acting as sole master of a synchronous single-port RAM for a CPU
// data port and a message loader. IDLE picks and latches a request, ACCESS
// drives the RAM for one cycle with a grant pulse, RDATA returns read data.
// Policy macro: MEM_ARB_ROUND_ROBIN_EN (see arb_pick2).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N = 6,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [1:0]   we,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] addr1,
    input  logic [W-1:0] wdata0,
    input  logic [W-1:0] wdata1,
    output logic [1:0]   gnt,
    output logic [1:0]   rvalid,
    output logic [W-1:0] rdata,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata,
    output logic         busy
);

    arb_state_t state;
    logic       win;
    logic       lat_win;
    logic       lat_we;
    logic       last;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic       last_q;
    assign last = last_q;
`else
    // Fixed priority has no pointer; the picker ignores this input.
    assign last = 1'b1;
`endif

    arb_pick2 u_pick (
        .req  (req),
        .last (last),
        .win  (win)
    );

    // Read data comes straight from the RAM; rvalid qualifies it.
    assign rdata = mem_rdata;

    // FSM with registered strobes; async reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            rvalid    <= 2'b00;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_win   <= 1'b0;
            lat_we    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        lat_win   <= win;
                        lat_we    <= we[win];
                        mem_we    <= we[win];
                        mem_addr  <= win ? addr1 : addr0;
                        mem_wdata <= win ? wdata1 : wdata0;
                        gnt       <= win ? 2'b10 : 2'b01;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    gnt    <= 2'b00;
                    mem_we <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_q <= lat_win;
`endif
                    if (lat_we) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rvalid <= lat_win ? 2'b10 : 2'b01;
                        state  <= RDATA;
                    end
                end
                RDATA: begin
                    rvalid <= 2'b00;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    gnt    <= 2'b00;
                    rvalid <= 2'b00;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
